// File: rtl/subtractor_nnbit_bitserial_if.sv
// Request/result handshake bundle for the bit-serial subtractor.
// The master side issues operands and consumes results; the slave side is the subtractor.
interface subtractor_nnbit_bitserial_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_num_a;
    logic [DATA_WIDTH-1:0] i_num_b;
    logic                  i_brw;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_res;
    logic                  o_brw;
    logic                  o_ovf;
    logic                  o_busy;

    modport master (
        output i_valid,
        input  o_ready,
        output i_num_a,
        output i_num_b,
        output i_brw,
        input  o_valid,
        output i_ready,
        input  o_res,
        input  o_brw,
        input  o_ovf,
        input  o_busy
    );

    modport slave (
        input  i_valid,
        output o_ready,
        input  i_num_a,
        input  i_num_b,
        input  i_brw,
        output o_valid,
        input  i_ready,
        output o_res,
        output o_brw,
        output o_ovf,
        output o_busy
    );
endinterface

// File: rtl/subtractor_nnbit_bitserial.sv
// Bit-serial a - b - brw: one difference bit per clock, LSB first, with a
// registered borrow chain; the result is published only once all bits are done.
module subtractor_nnbit_bitserial #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    subtractor_nnbit_bitserial_if.slave  bus
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam int MSB = DATA_WIDTH - 1;

    if (DATA_WIDTH < 1 || DATA_WIDTH > 64) begin : g_bad_width
        $error("DATA_WIDTH must be in 1..64");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // One full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic brw);
        logic d;
        logic bo;
        d  = a ^ b ^ brw;
        bo = (~a & b) | (~(a ^ b) & brw);
        return {bo, d};
    endfunction

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  brw_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0] acc_d;
    logic [DATA_WIDTH-1:0] res_q;
    logic                  res_brw_q;
    logic                  res_ovf_q;
    logic [1:0]            step;
    logic                  last_bit;
    logic                  accept;
    logic                  ready_s;
    logic                  valid_s;
    logic                  busy_s;

    assign step     = sub_bit(a_q[cnt_q], b_q[cnt_q], brw_q);
    assign last_bit = (cnt_q == LAST_BIT);
    assign accept   = (state_q == IDLE) && bus.i_valid;

    always_comb begin
        acc_d        = acc_q;
        acc_d[cnt_q] = step[0];
    end

    always_comb begin
        state_d = state_q;
        ready_s = 1'b0;
        valid_s = 1'b0;
        busy_s  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_s = 1'b1;
                if (bus.i_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                busy_s = 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_s = 1'b1;
                if (bus.i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and published result: reset clears everything so an aborted
    // operation can never surface.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            brw_q     <= 1'b0;
            res_q     <= '0;
            res_brw_q <= 1'b0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q <= '0;
                brw_q <= bus.i_brw;
            end else if (state_q == CALC) begin
                brw_q <= step[1];
                if (!last_bit) begin
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    res_q     <= acc_d;
                    res_brw_q <= step[1];
                    res_ovf_q <= (a_q[MSB] ^ b_q[MSB]) & (step[0] ^ a_q[MSB]);
                end
            end
        end
    end

    // Operand and partial-difference storage; every bit is rewritten per operation.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            a_q <= bus.i_num_a;
            b_q <= bus.i_num_b;
        end
        if (state_q == CALC) begin
            acc_q <= acc_d;
        end
    end

    assign bus.o_ready = ready_s;
    assign bus.o_valid = valid_s;
    assign bus.o_busy  = busy_s;
    assign bus.o_res   = res_q;
    assign bus.o_brw   = res_brw_q;
    assign bus.o_ovf   = res_ovf_q;
endmodule

// File: tb/tb_subtractor_nnbit_bitserial.sv
// Directed bench for the bit-serial subtractor at DATA_WIDTH = 8.
module tb_subtractor_nnbit_bitserial;
    localparam int DATA_WIDTH = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    subtractor_nnbit_bitserial_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

    subtractor_nnbit_bitserial #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!bus.o_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, 64'(bus.o_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic brw, input logic [7:0] exp_res, input logic exp_brw,
                          input logic exp_ovf, input int hold);
        int n;
        wait_ready(tag);
        bus.i_valid = 1'b1;
        bus.i_num_a = a;
        bus.i_num_b = b;
        bus.i_brw   = brw;
        tick();
        chk({tag, "_busy"}, 64'(bus.o_busy), 64'd1);
        n = 0;
        while (!bus.o_valid && n < 100) begin
            bus.i_valid = ~bus.i_valid;
            bus.i_num_a = 8'($urandom);
            bus.i_num_b = 8'($urandom);
            bus.i_brw   = 1'($urandom);
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(DATA_WIDTH));
        for (int i = 0; i < hold; i++) begin
            bus.i_valid = 1'($urandom);
            bus.i_num_a = 8'($urandom);
            bus.i_num_b = 8'($urandom);
            tick();
            chk({tag, "_hold_valid"}, 64'(bus.o_valid), 64'd1);
            chk({tag, "_hold_ready"}, 64'(bus.o_ready), 64'd0);
            chk({tag, "_hold_res"}, 64'(bus.o_res), 64'(exp_res));
        end
        chk({tag, "_res"}, 64'(bus.o_res), 64'(exp_res));
        chk({tag, "_brw"}, 64'(bus.o_brw), 64'(exp_brw));
        chk({tag, "_ovf"}, 64'(bus.o_ovf), 64'(exp_ovf));
        chk({tag, "_done_ready"}, 64'(bus.o_ready), 64'd0);
        chk({tag, "_done_busy"}, 64'(bus.o_busy), 64'd0);
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        chk({tag, "_after_valid"}, 64'(bus.o_valid), 64'd0);
        chk({tag, "_after_ready"}, 64'(bus.o_ready), 64'd1);
        chk({tag, "_kept_res"}, 64'(bus.o_res), 64'(exp_res));
    endtask

    initial begin
        int nv;
        total = 0;
        bad   = 0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        bus.i_num_a = '0;
        bus.i_num_b = '0;
        bus.i_brw   = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", 64'(bus.o_ready), 64'd1);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_res", 64'(bus.o_res), 64'd0);
        chk("rst_brw", 64'(bus.o_brw), 64'd0);
        chk("rst_ovf", 64'(bus.o_ovf), 64'd0);

        run_op("basic",     8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 0);
        run_op("underflow", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
        run_op("sovf",      8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
        run_op("brwin",     8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
        run_op("sovf_neg",  8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0);
        run_op("brw_zero",  8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 0);
        run_op("backpress", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 5);

        // Abort in the middle of CALC, with bit 4 about to be processed.
        wait_ready("abort");
        bus.i_valid = 1'b1;
        bus.i_num_a = 8'h35;
        bus.i_num_b = 8'h12;
        bus.i_brw   = 1'b0;
        tick();
        bus.i_valid = 1'b0;
        repeat (4) tick();
        chk("abort_busy_pre", 64'(bus.o_busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", 64'(bus.o_ready), 64'd1);
        chk("abort_busy", 64'(bus.o_busy), 64'd0);
        chk("abort_res", 64'(bus.o_res), 64'd0);
        chk("abort_valid", 64'(bus.o_valid), 64'd0);
        nv = 0;
        repeat (12) begin
            tick();
            if (bus.o_valid) nv++;
        end
        chk("abort_no_valid", 64'(nv), 64'd0);
        run_op("post_abort", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
